cmp_result_monitor: RTL

- Sits directly downstream of the 4-bit magnitude comparator (`comp`).
- Consumes its `less`/`greater`/`equal` flags, one result per `in_valid` cycle.
- Keeps saturating per-outcome counters.
- Debounces the result stream into a three-state window FSM (NEUTRAL/HIGH/LOW) that drives registered alarm outputs for downstream control logic.

---
 rtl/cmp_result_monitor.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cmp_result_monitor.sv
// Monitors comparator flags: saturating outcome counters plus a debounced NEUTRAL/HIGH/LOW window FSM.
// Define CMP_MON_STICKY_ERR_EN to make err sticky until clear or reset.

module cmp_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

module cmp_result_monitor #(
    parameter int CNT_W    = 8,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             less,
    input  logic             greater,
    input  logic             equal,
    input  logic             clear,
    output logic             alarm_hi,
    output logic             alarm_lo,
    output logic             match,
    output logic             err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cnt_less,
    output logic [CNT_W-1:0] cnt_greater,
    output logic [CNT_W-1:0] cnt_equal
);
    typedef enum logic [1:0] {
        ST_NEUTRAL = 2'b00,
        ST_HIGH    = 2'b01,
        ST_LOW     = 2'b10
    } state_t;

    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    state_t                      state_q, state_d;
    logic   [3:0]                run_q, run_d, run_nxt;
    logic                        dir_q, dir_d;
    logic                        onehot, accept, bad;
    logic   [2:0]                hit;
    logic   [2:0][CNT_W-1:0]     cnt_q;

    // Exactly one flag: odd population, but not all three.
    assign onehot = (less ^ greater ^ equal) & ~(less & greater & equal);
    assign accept = in_valid & onehot & ~clear;
    assign bad    = in_valid & ~onehot & ~clear;
    assign hit    = {equal, greater, less} & {3{accept}};

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_cnt
            cmp_sat_cnt #(.W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clear),
                .inc   (hit[i]),
                .cnt   (cnt_q[i])
            );
        end
    endgenerate

    assign cnt_less    = cnt_q[0];
    assign cnt_greater = cnt_q[1];
    assign cnt_equal   = cnt_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NEUTRAL;
            run_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            dir_q   <= dir_d;
        end
    end

    assign run_nxt = run_q + 4'd1;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        dir_d   = dir_q;
        if (clear) begin
            state_d = ST_NEUTRAL;
            run_d   = '0;
            dir_d   = 1'b0;
        end else if (bad) begin
            run_d = '0;
        end else if (accept) begin
            case (state_q)
                ST_NEUTRAL: begin
                    if (equal) begin
                        run_d = '0;
                    end else begin
                        // dir_q remembers which way the NEUTRAL streak is heading
                        dir_d = greater;
                        run_d = (run_q != 4'd0 && dir_q == greater) ? run_nxt : 4'd1;
                        if (run_d == DEB) begin
                            state_d = greater ? ST_HIGH : ST_LOW;
                            run_d   = '0;
                        end
                    end
                end
                ST_HIGH: begin
                    run_d = greater ? 4'd0 : run_nxt;
                    if (run_d == DEB) begin
                        state_d = ST_NEUTRAL;
                        run_d   = '0;
                    end
                end
                ST_LOW: begin
                    run_d = less ? 4'd0 : run_nxt;
                    if (run_d == DEB) begin
                        state_d = ST_NEUTRAL;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_NEUTRAL;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hi <= 1'b0;
            alarm_lo <= 1'b0;
            match    <= 1'b0;
            err      <= 1'b0;
        end else begin
            alarm_hi <= (state_d == ST_HIGH);
            alarm_lo <= (state_d == ST_LOW);
            if (clear)
                match <= 1'b0;
            else if (accept)
                match <= equal;
            if (clear)
                err <= 1'b0;
            else
`ifdef CMP_MON_STICKY_ERR_EN
                err <= err | bad;
`else
                err <= bad;
`endif
        end
    end

    assign state = state_q;

endmodule
